// File: rtl/fanout_responder_pkg.sv
// fanout_responder_pkg: shared sizing helpers and handshake constants for the fan-out responder.
package fanout_responder_pkg;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // One extra pointer bit separates a full buffer from an empty one.
    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    localparam int ACK_PULSE_CYCLES = 1;

endpackage

// File: rtl/fanout_responder_if.sv
// fanout_responder_if: push-side stream, per-consumer pull handshake and status of the responder.
interface fanout_responder_if
    import fanout_responder_pkg::*;
#(
    parameter int data_width = 32,
    parameter int depth = 4,
    parameter int output_size = 2
);
    localparam int pw = ptr_w(depth);
    logic s_valid;
    logic s_ready;
    logic [data_width-1:0] s_data;
    logic [output_size-1:0] req;
    logic [output_size-1:0] ack;
    logic [data_width*output_size-1:0] dout;
    logic [31:0] count;
    logic [pw-1:0] level;

    modport master(output s_valid, s_data, req, input s_ready, ack, dout, count, level);
    modport slave(input s_valid, s_data, req, output s_ready, ack, dout, count, level);
endinterface

// File: rtl/fanout_responder_read_port.sv
// fanout_read_port: one consumer's read pointer, ack pulse and registered data lane.
module fanout_read_port
    import fanout_responder_pkg::*;
#(
    parameter int data_width = 32,
    parameter int depth = 4,
    parameter int pw = ptr_w(depth)
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic [pw-1:0] wr_ptr,
    input  logic [data_width-1:0] mem [depth],
    output logic ack,
    output logic [data_width-1:0] dout,
    output logic [pw-1:0] lag,
    output logic rd_en
);
    logic [pw-1:0] rd_ptr;

    assign lag = wr_ptr - rd_ptr;
    // Gating on ack limits each consumer to one datum every other cycle.
    assign rd_en = req & ~ack & (lag != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            ack <= 1'b0;
            dout <= '0;
        end else begin
            ack <= rd_en;
            if (rd_en) begin
                dout <= mem[rd_ptr[pw-2:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fanout_responder.sv
// fanout_responder: elastic buffer taking a valid/ready stream and serving every datum
// in order to each of output_size req/ack consumers.
module fanout_responder
    import fanout_responder_pkg::*;
#(
    parameter int data_width = 32,
    parameter int depth = 4,
    parameter int output_size = 2
) (
    input logic clk,
    input logic rst,
    fanout_responder_if.slave bus
);
    localparam int pw = ptr_w(depth);

    logic [data_width-1:0] mem [depth];
    logic [pw-1:0] wr_ptr;
    logic [pw-1:0] lag [output_size];
    logic [pw-1:0] level;
    logic [output_size-1:0] rd_en;
    logic [output_size-1:0] ack;
    logic [data_width*output_size-1:0] dout;
    logic [31:0] count;
    logic s_ready;
    logic wr;
    logic retire;

    genvar i;
    generate
        for (i = 0; i < output_size; i++) begin : g_port
            fanout_read_port #(.data_width(data_width), .depth(depth)) u_port (
                .clk(clk),
                .rst(rst),
                .req(bus.req[i]),
                .wr_ptr(wr_ptr),
                .mem(mem),
                .ack(ack[i]),
                .dout(dout[data_width*i +: data_width]),
                .lag(lag[i]),
                .rd_en(rd_en[i])
            );
        end
    endgenerate

    // The oldest entry retires when every consumer still owing it reads it on this edge.
    always_comb begin
        level = '0;
        retire = 1'b0;
        for (int k = 0; k < output_size; k++) level = (lag[k] > level) ? lag[k] : level;
        retire = (level != '0);
        for (int k = 0; k < output_size; k++) retire = retire & ((lag[k] != level) | rd_en[k]);
    end

    assign s_ready = rst & (level != pw'(depth));
    assign wr = bus.s_valid & s_ready;

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr[pw-2:0]] <= bus.s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + pw'(wr);
            count <= count + 32'(retire);
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.ack = ack;
    assign bus.dout = dout;
    assign bus.count = count;
    assign bus.level = level;
endmodule

// File: tb/tb_fanout_responder.sv
// tb_fanout_responder: directed scenarios for the fan-out responder with depth 4 and two consumers.
module tb_fanout_responder;
    import fanout_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int b2b = 0;
    int run0 = 0;
    int run1 = 0;
    int max_level = 0;

    fanout_responder_if #(.data_width(32), .depth(4), .output_size(2)) bus();
    fanout_responder #(.data_width(32), .depth(4), .output_size(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Collect deliveries per lane, watch ack width and the peak occupancy.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.ack[0]) q0.push_back(bus.dout[31:0]);
            if (bus.ack[1]) q1.push_back(bus.dout[63:32]);
            run0 = bus.ack[0] ? run0 + 1 : 0;
            run1 = bus.ack[1] ? run1 + 1 : 0;
            if (run0 > ACK_PULSE_CYCLES || run1 > ACK_PULSE_CYCLES) b2b++;
            if (int'(bus.level) > max_level) max_level = int'(bus.level);
        end
    end

    function automatic bit seq_ok(input bit lane, input int first, input int n);
        logic [31:0] q[$];
        if (lane) q = q1;
        else q = q0;
        if (q.size() != n) return 1'b0;
        for (int k = 0; k < n; k++) if (q[k] !== 32'(first + k)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        bus.s_valid = 1'b0;
        bus.req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        b2b = 0;
        run0 = 0;
        run1 = 0;
        max_level = 0;
    endtask

    task automatic push_seq(input int first, input int n, input bit rnd);
        int k = 0;
        int g = 0;
        bit acc;
        while (k < n && g < 3000) begin
            @(negedge clk);
            g++;
            bus.s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd) bus.req = 2'($urandom_range(0, 3));
            bus.s_data = 32'(first + k);
            acc = bus.s_valid & bus.s_ready;
            @(posedge clk);
            if (acc) k++;
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        checks++;
        if (k != n) begin errors++; $display("FAIL push_accept accepted=%0d wanted=%0d", k, n); end
    endtask

    task automatic drain();
        int g = 0;
        bus.req = 2'b11;
        do begin
            @(negedge clk);
            g++;
        end while ((bus.level != 0 || bus.ack != 0) && g < 200);
        checks++;
        if (g >= 200) begin errors++; $display("FAIL drain_timeout level=%0d wanted=0", bus.level); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data = 32'hDEAD_BEEF;
        bus.req = 2'b11;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%b want=0", bus.s_ready); end
        if (bus.ack !== 2'b00) begin errors++; $display("FAIL rst_ack got=%b want=00", bus.ack); end
        if (bus.dout !== 64'd0) begin errors++; $display("FAIL rst_dout got=%h want=0", bus.dout); end
        if (bus.count !== 32'd0) begin errors++; $display("FAIL rst_count got=%0d want=0", bus.count); end
        if (bus.level !== 3'd0) begin errors++; $display("FAIL rst_level got=%0d want=0", bus.level); end
        bus.s_valid = 1'b0;
        bus.req = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_s_ready got=%b want=1", bus.s_ready); end
    endtask

    task automatic test_stream();
        do_reset();
        bus.req = 2'b11;
        push_seq(1, 10, 1'b0);
        drain();
        checks += 5;
        if (!seq_ok(0, 1, 10)) begin errors++; $display("FAIL stream_lane0 size=%0d want 1..10", q0.size()); end
        if (!seq_ok(1, 1, 10)) begin errors++; $display("FAIL stream_lane1 size=%0d want 1..10", q1.size()); end
        if (bus.count !== 32'd10) begin errors++; $display("FAIL stream_count got=%0d want=10", bus.count); end
        if (bus.level !== 3'd0) begin errors++; $display("FAIL stream_level got=%0d want=0", bus.level); end
        if (b2b != 0) begin errors++; $display("FAIL stream_ack_b2b got=%0d want=0", b2b); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.req = 2'b01;
        push_seq(1, 4, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data = 32'd5;
        repeat (8) @(negedge clk);
        checks += 4;
        if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready got=%b want=0", bus.s_ready); end
        if (bus.level !== 3'd4) begin errors++; $display("FAIL stall_level got=%0d want=4", bus.level); end
        if (!seq_ok(0, 1, 4)) begin errors++; $display("FAIL stall_lane0 size=%0d want 1..4", q0.size()); end
        if (bus.count !== 32'd0) begin errors++; $display("FAIL stall_count got=%0d want=0", bus.count); end
        bus.req = 2'b11;
        @(negedge clk);
        checks += 4;
        if (bus.ack !== 2'b10) begin errors++; $display("FAIL unstall_ack got=%b want=10", bus.ack); end
        if (bus.dout[63:32] !== 32'd1) begin errors++; $display("FAIL unstall_lane1 got=%0d want=1", bus.dout[63:32]); end
        if (bus.count !== 32'd1) begin errors++; $display("FAIL unstall_count got=%0d want=1", bus.count); end
        if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL unstall_s_ready got=%b want=1", bus.s_ready); end
        @(negedge clk);
        bus.s_valid = 1'b0;
        checks++;
        if (bus.level !== 3'd4) begin errors++; $display("FAIL unstall_level got=%0d want=4", bus.level); end
        drain();
        checks += 3;
        if (!seq_ok(0, 1, 5)) begin errors++; $display("FAIL stall_final_lane0 size=%0d want 1..5", q0.size()); end
        if (!seq_ok(1, 1, 5)) begin errors++; $display("FAIL stall_final_lane1 size=%0d want 1..5", q1.size()); end
        if (bus.count !== 32'd5) begin errors++; $display("FAIL stall_final_count got=%0d want=5", bus.count); end
    endtask

    task automatic test_latency();
        do_reset();
        bus.req = 2'b11;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data = 32'hA5;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ack !== 2'b00) begin errors++; $display("FAIL lat_edge_n_ack got=%b want=00", bus.ack); end
        @(negedge clk);
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
        checks += 5;
        if (bus.ack !== 2'b11) begin errors++; $display("FAIL lat_ack got=%b want=11", bus.ack); end
        if (bus.dout[31:0] !== 32'hA5) begin errors++; $display("FAIL lat_lane0 got=%h want=a5", bus.dout[31:0]); end
        if (bus.dout[63:32] !== 32'hA5) begin errors++; $display("FAIL lat_lane1 got=%h want=a5", bus.dout[63:32]); end
        if (bus.count !== 32'd1) begin errors++; $display("FAIL lat_count got=%0d want=1", bus.count); end
        if (bus.level !== 3'd0) begin errors++; $display("FAIL lat_level got=%0d want=0", bus.level); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.ack !== 2'b00) begin errors++; $display("FAIL lat_pulse_width got=%b want=00", bus.ack); end
    endtask

    task automatic test_wrap_throttle();
        do_reset();
        void'($urandom(32'd1234));
        push_seq(0, 40, 1'b1);
        drain();
        checks += 5;
        if (!seq_ok(0, 0, 40)) begin errors++; $display("FAIL wrap_lane0 size=%0d want 0..39", q0.size()); end
        if (!seq_ok(1, 0, 40)) begin errors++; $display("FAIL wrap_lane1 size=%0d want 0..39", q1.size()); end
        if (bus.count !== 32'd40) begin errors++; $display("FAIL wrap_count got=%0d want=40", bus.count); end
        if (max_level > 4) begin errors++; $display("FAIL wrap_max_level got=%0d want<=4", max_level); end
        if (b2b != 0) begin errors++; $display("FAIL wrap_ack_b2b got=%0d want=0", b2b); end
    endtask

    task automatic test_async_reset();
        do_reset();
        push_seq(1, 3, 1'b0);
        bus.req = 2'b01;
        @(posedge clk);
        #1;
        checks += 2;
        if (bus.ack !== 2'b01) begin errors++; $display("FAIL arst_pre_ack got=%b want=01", bus.ack); end
        if (bus.level !== 3'd3) begin errors++; $display("FAIL arst_pre_level got=%0d want=3", bus.level); end
        #2 rst = 1'b0;
        #1;
        checks += 4;
        if (bus.ack !== 2'b00) begin errors++; $display("FAIL arst_ack got=%b want=00", bus.ack); end
        if (bus.level !== 3'd0) begin errors++; $display("FAIL arst_level got=%0d want=0", bus.level); end
        if (bus.count !== 32'd0) begin errors++; $display("FAIL arst_count got=%0d want=0", bus.count); end
        if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL arst_s_ready got=%b want=0", bus.s_ready); end
        @(negedge clk);
        bus.req = 2'b00;
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst = 1'b1;
        bus.req = 2'b11;
        push_seq(32'h77, 1, 1'b0);
        drain();
        checks += 3;
        if (!seq_ok(0, 32'h77, 1)) begin errors++; $display("FAIL arst_next_lane0 size=%0d want {77}", q0.size()); end
        if (!seq_ok(1, 32'h77, 1)) begin errors++; $display("FAIL arst_next_lane1 size=%0d want {77}", q1.size()); end
        if (bus.count !== 32'd1) begin errors++; $display("FAIL arst_next_count got=%0d want=1", bus.count); end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.req = 2'b00;
        test_reset();
        test_stream();
        test_stall();
        test_latency();
        test_wrap_throttle();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fanout_responder.md
Name: fanout_responder

Overview:
- Elastic fan-out buffer that terminates a push stream (valid/ready) and serves it to `output_size` pull-style consumers.
- Consumers use the req/ack pull handshake: the consumer holds `req`; the responder answers with a one-cycle `ack` pulse and registered data.
- Every datum is delivered exactly once, in order, to every consumer. An entry is freed only after all consumers have taken it.
- Sits between a streaming source (DMA/loader) and the dataflow graph inputs. It is the responder end that the graph's `in` operators pull from.

Parameters:
- data_width, 32, width of one datum.
- depth, 4, buffer entries; power of 2, ≥2.
- output_size, 2, number of consumers; ≥1.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- s_valid  in  1  push-side datum valid.
- s_ready  out  1  push-side buffer can accept.
- s_data  in  data_width  push-side datum.
- req  in  output_size  per-consumer pull request (level).
- ack  out  output_size  per-consumer one-cycle delivery pulse.
- dout  out  data_width*output_size  per-consumer data lane; lane i is bits [data_width*(i+1)-1 : data_width*i].
- count  out  32  entries retired, i.e. taken by all consumers.
- level  out  clog2(depth)+1  occupied entries (written, not yet retired).

Behaviour:
- Reset (rst low, asynchronous):
  - wr_ptr=0, every rd_ptr_i=0, ack=0, dout=0, count=0, level=0.
  - s_ready=0 while rst is low. s_ready=1 from the first cycle after release.
- Pointers are clog2(depth)+1 bits and wrap naturally. lag_i = wr_ptr - rd_ptr_i (modular). lag_i ≤ depth always.
- level = max_i(lag_i). full = (level == depth). s_ready = rst & ~full, computed from registered state only.
- Write: on an edge with s_valid & s_ready, mem[wr_ptr mod depth] <= s_data and wr_ptr increments.
  - No read bypass: an entry written at edge N is first readable at edge N+1.
- Read port i, every edge:
  - If req[i] & ~ack[i] & lag_i>0: ack[i]<=1, dout_i<=mem[rd_ptr_i mod depth], rd_ptr_i increments.
  - Otherwise ack[i]<=0 and dout_i holds its last value.
- Back-to-back acks to one consumer are impossible. Maximum rate per consumer is one datum every 2 cycles.
- Consumers are independent. A stalled consumer does not block the others until its lag reaches depth; at that point s_ready=0 for everyone.
- Retire: the oldest entry retires when every rd_ptr_i has passed it. Because each rd_ptr advances at most 1 per edge, count increments by at most 1 per edge.
  - count wraps at 2^32.
- Simultaneous write and read on a full buffer: the write is refused (s_ready already 0). The read proceeds, and s_ready rises the following cycle if a retire occurred.
- Simultaneous write and read on an empty entry set (lag_i=0): the read is refused this edge, and ack[i] may pulse next edge.
- req dropping while ack is high has no effect. The datum already delivered counts as taken.
- Reset mid-operation: all buffered data is discarded. ack falls asynchronously with rst; no partial delivery is recorded.
- Latency: s_valid accepted at edge N, with a requesting, empty-lag consumer → ack at edge N+1.

Decomposition:
- Shared package holds:
  - the clog2 function;
  - the pointer-width constant expression;
  - the handshake pulse-width rule (ack one cycle) as a named constant for the bench.
- Sub-module fanout_read_port: one per consumer, instantiated via generate over output_size. It holds rd_ptr_i, ack[i], dout_i, and the lag_i compute.
- The top module owns mem, wr_ptr, the max/retire logic, s_ready and count.

Test Plan:
1. Reset: hold rst=0 with s_valid=1 → s_ready=0, ack=0, dout=0, count=0, level=0. Release → s_ready=1 the next cycle.
2. depth=4, output_size=2, both req held high, push 1..10 with s_valid always high → each lane receives 1..10 in order with ack pulsing every other cycle; count ends at 10, level ends at 0.
3. req[1]=0, push 1..5 → 4 accepted, then s_ready=0 and level=4; consumer 0 still receives 1..4. Raise req[1] → lane 1 receives 1, count=1, s_ready=1, and 5 is then accepted.
4. Latency: single push of 0xA5 at edge N with both req high and buffer empty → ack=2'b11 and both lanes =0xA5 at edge N+1, never at N.
5. Wrap and throttle: push 0..39 with pseudo-random s_valid and req (seeded) → both lanes see 0..39 in order with no gaps or repeats, count=40, and level never exceeds 4.
6. Async reset mid-stream: drop rst between edges while level=3 and ack=1 → ack=0 immediately. After release: level=0, count=0, and the next push is delivered first.
